// File: rtl/abacus_wb_poller.sv
// -----------------------------------------------------------------------------
// abacus_wb_poller
//   Wishbone classic master that drives the ABACUS profiler slave port from
//   the host side. It issues single control-register writes and snapshot bursts
//   that read NUM_READS consecutive counter words. Each word is presented on a
//   valid/ready stream.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   wr_req/wr_offset/wr_data  single-cycle write request (offset from base)
//   snap_req                  single-cycle snapshot request
//   busy, done, err           status: in progress, completion pulse, timeout
//   out_valid/out_ready       snapshot word stream handshake
//   out_data/out_index/out_last  word payload, index, final-word flag
//   wb_*                      Wishbone classic master port
//
// All outputs come straight from flops. The flops are loaded from the
// next-state decode, so the outputs line up with the state they describe.
// -----------------------------------------------------------------------------
module abacus_wb_poller #(
   parameter logic [31:0] ABACUS_BASE_ADDR = 32'hf0030000,
   parameter logic [31:0] READ_OFFSET      = 32'h10,
   parameter int unsigned NUM_READS        = 8,
   parameter int unsigned TIMEOUT_CYCLES   = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_req,
   input  logic [7:0]  wr_offset,
   input  logic [31:0] wr_data,
   input  logic        snap_req,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [3:0]  out_index,
   output logic        out_last,
   output logic        wb_cyc,
   output logic        wb_stb,
   output logic        wb_we,
   output logic [31:0] wb_adr,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_BUS,
      S_RD_BUS,
      S_PUSH,
      S_FINISH
   } state_e;

   localparam logic [3:0]  LAST_IDX  = 4'(NUM_READS - 1);
   localparam logic [6:0]  WAIT_MAX  = 7'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] READ_BASE = ABACUS_BASE_ADDR + READ_OFFSET;

   state_e      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [6:0]  wait_q, wait_d;
   logic        err_q, err_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] dato_q, dato_d;
   logic [31:0] rdata_q, rdata_d;
   logic        busy_q, done_q, valid_q, last_q, cyc_q, we_q;
   logic        busy_d, done_d, valid_d, last_d, cyc_d, we_d;
   logic [3:0]  idx_inc;

   assign idx_inc = idx_q + 4'd1;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wait_d  = wait_q;
      err_d   = err_q;
      adr_d   = adr_q;
      dato_d  = dato_q;
      rdata_d = rdata_q;

      case (state_q)
         S_IDLE: begin
            // A write wins over a simultaneous snapshot; the snapshot is dropped.
            if (wr_req) begin
               state_d = S_WR_BUS;
               adr_d   = ABACUS_BASE_ADDR + {24'd0, wr_offset};
               dato_d  = wr_data;
               err_d   = 1'b0;
               wait_d  = '0;
            end else if (snap_req) begin
               state_d = S_RD_BUS;
               idx_d   = '0;
               adr_d   = READ_BASE;
               err_d   = 1'b0;
               wait_d  = '0;
            end
         end
         S_WR_BUS: begin
            if (wb_ack) begin
               state_d = S_FINISH;
            end else if (wait_q == WAIT_MAX) begin
               state_d = S_FINISH;
               err_d   = 1'b1;
            end else begin
               wait_d  = wait_q + 7'd1;
            end
         end
         S_RD_BUS: begin
            if (wb_ack) begin
               state_d = S_PUSH;
               rdata_d = wb_dat_i;
            end else if (wait_q == WAIT_MAX) begin
               // Aborted burst: go straight to FINISH so no further word is presented.
               state_d = S_FINISH;
               err_d   = 1'b1;
            end else begin
               wait_d  = wait_q + 7'd1;
            end
         end
         S_PUSH: begin
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_FINISH;
               end else begin
                  state_d = S_RD_BUS;
                  idx_d   = idx_inc;
                  adr_d   = READ_BASE + {26'd0, idx_inc, 2'b00};
                  wait_d  = '0;
               end
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_FINISH);
      cyc_d   = (state_d == S_WR_BUS) || (state_d == S_RD_BUS);
      we_d    = (state_d == S_WR_BUS);
      valid_d = (state_d == S_PUSH);
      last_d  = (state_d == S_PUSH) && (idx_d == LAST_IDX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         wait_q  <= '0;
         err_q   <= 1'b0;
         adr_q   <= '0;
         dato_q  <= '0;
         rdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         adr_q   <= adr_d;
         dato_q  <= dato_d;
         rdata_q <= rdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign out_valid = valid_q;
   assign out_data  = rdata_q;
   assign out_index = idx_q;
   assign out_last  = last_q;
   assign wb_cyc    = cyc_q;
   assign wb_stb    = cyc_q;
   assign wb_we     = we_q;
   assign wb_adr    = adr_q;
   assign wb_dat_o  = dato_q;

endmodule

// File: tb/tb_abacus_wb_poller.sv
// -----------------------------------------------------------------------------
// tb_abacus_wb_poller
//   Self-checking bench for abacus_wb_poller: a table of single writes, hand
//   sequences for snapshot, backpressure, timeout, request collisions and
//   mid-burst reset, then a randomized run scored against a transaction-level
//   model (expected write list and expected word list).
// -----------------------------------------------------------------------------
module tb_abacus_wb_poller;

   localparam logic [31:0] BASE  = 32'hf0030000;
   localparam logic [31:0] RDOFF = 32'h10;
   localparam int          NR    = 8;
   localparam int          TO    = 64;

   logic        clk = 1'b0;
   logic        rst, wr_req, snap_req, out_ready;
   logic [7:0]  wr_offset;
   logic [31:0] wr_data;
   logic        busy, done, err, out_valid, out_last;
   logic [31:0] out_data;
   logic [3:0]  out_index;
   logic        wb_cyc, wb_stb, wb_we, wb_ack;
   logic [31:0] wb_adr, wb_dat_o, wb_dat_i;

   always #5 clk = ~clk;

   abacus_wb_poller #(
      .ABACUS_BASE_ADDR(BASE), .READ_OFFSET(RDOFF),
      .NUM_READS(NR), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .wr_req(wr_req), .wr_offset(wr_offset), .wr_data(wr_data),
      .snap_req(snap_req),
      .busy(busy), .done(done), .err(err),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .out_last(out_last),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
      .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack)
   );

   int errors = 0;
   int checks = 0;

   // ---------------- slave model ----------------
   logic [7:0]  lat_cnt   = 8'd0;
   logic [7:0]  rnd_lat   = 8'd0;
   logic [7:0]  fixed_lat = 8'd0;     // 255 = never ack
   bit          rand_lat  = 1'b0;
   bit          data_mode = 1'b0;     // 1: word i reads back 0x100+i
   logic [31:0] seed      = 32'h0;

   assign wb_ack   = wb_cyc && wb_stb && (lat_cnt == (rand_lat ? rnd_lat : fixed_lat));
   assign wb_dat_i = data_mode ? (32'h100 + ((wb_adr - BASE - RDOFF) >> 2)) : (wb_adr ^ seed);

   always @(posedge clk) begin
      if (wb_cyc && wb_stb && !wb_ack) lat_cnt <= lat_cnt + 8'd1;
      else                             lat_cnt <= 8'd0;
      if (wb_ack) rnd_lat <= 8'($urandom_range(0, 3));
   end

   // ---------------- monitor ----------------
   typedef struct packed {logic [31:0] d; logic [3:0] idx; logic last;} word_t;
   typedef struct packed {logic [31:0] adr; logic [31:0] dat;} wr_t;

   word_t got_w[$];
   wr_t   got_wr[$];
   int    done_cnt = 0, valid_cnt = 0, rdcyc_cnt = 0;
   int    hold_bad = 0, push_bus_bad = 0, last_bad = 0;
   bit    pv = 1'b0, pr = 1'b0;
   word_t pw = '0;

   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) got_w.push_back('{out_data, out_index, out_last});
         if (wb_cyc && wb_stb && wb_ack && wb_we) got_wr.push_back('{wb_adr, wb_dat_o});
         if (wb_cyc && !wb_we) rdcyc_cnt++;
         if (done) done_cnt++;
         if (out_valid) valid_cnt++;
         if (pv && !pr && (!out_valid || word_t'({out_data, out_index, out_last}) != pw)) hold_bad++;
         if (out_valid && wb_cyc) push_bus_bad++;
         if (out_last != (out_valid && out_index == 4'(NR - 1))) last_bad++;
      end
      pv = out_valid && !rst;
      pr = out_ready;
      pw = '{out_data, out_index, out_last};
   end

   // ---------------- helpers ----------------
   bit noise = 1'b0, rand_rdy = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
      wr_req = 1'b0; snap_req = 1'b0;
      if (noise && busy) begin
         wr_req    = ($urandom_range(0, 7) == 0);
         snap_req  = ($urandom_range(0, 7) == 0);
         wr_offset = 8'($urandom);
         wr_data   = $urandom;
      end
      if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (busy && n < bound) begin step(); n++; end
      if (busy) begin
         checks++; errors++;
         $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", n);
      end
   endtask

   task automatic wait_word(input logic [3:0] idx, input int bound);
      int n = 0;
      while (!(out_valid && out_index == idx) && n < bound) begin step(); n++; end
      if (!(out_valid && out_index == idx)) begin
         checks++; errors++;
         $display("FAIL wait_word: word %0d not presented within %0d cycles", idx, n);
      end
   endtask

   function automatic logic [31:0] exp_data(input int i);
      logic [31:0] a;
      a = BASE + RDOFF + 32'(4 * i);
      return data_mode ? 32'(32'h100 + i) : (a ^ seed);
   endfunction

   typedef struct {
      logic [7:0]  off;
      logic [31:0] dat;
      logic [7:0]  lat;
      logic [31:0] exp_adr;
      int          exp_done;   // cycle of done pulse, counting the first bus cycle as 1
   } wvec_t;

   initial begin
      wvec_t tv[4];
      word_t exp_w[$];
      wr_t   exp_wr[$];
      int    w0, wr0, d0, v0, r0, n;

      tv[0] = '{8'h04, 32'h00000001, 8'd0, 32'hf0030004, 2};
      tv[1] = '{8'h00, 32'hdeadbeef, 8'd0, 32'hf0030000, 2};
      tv[2] = '{8'hfc, 32'h00000000, 8'd2, 32'hf00300fc, 4};
      tv[3] = '{8'h40, 32'h12345678, 8'd5, 32'hf0030040, 7};

      rst = 1'b1; wr_req = 1'b0; snap_req = 1'b0; out_ready = 1'b1;
      wr_offset = '0; wr_data = '0;
      seed = $urandom;
      repeat (3) step();
      chk("rst_ctrl", 32'({busy, done, err, out_valid, out_last, wb_cyc, wb_stb, wb_we}), 32'h0);
      chk("rst_adr", wb_adr, 32'h0);
      chk("rst_dat_o", wb_dat_o, 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_out_index", 32'(out_index), 32'h0);
      rst = 1'b0;
      step();

      // ---- table of single writes ----
      for (int t = 0; t < 4; t++) begin
         fixed_lat = tv[t].lat;
         wr_offset = tv[t].off; wr_data = tv[t].dat; wr_req = 1'b1;
         step();
         chk($sformatf("wr%0d_bus", t), 32'({busy, wb_cyc, wb_stb, wb_we}), 32'hf);
         chk($sformatf("wr%0d_adr", t), wb_adr, tv[t].exp_adr);
         chk($sformatf("wr%0d_dat", t), wb_dat_o, tv[t].dat);
         n = 1;
         while (!done && n < 50) begin step(); n++; end
         chk($sformatf("wr%0d_done_cycle", t), 32'(n), 32'(tv[t].exp_done));
         chk($sformatf("wr%0d_fin", t), 32'({busy, err, wb_cyc}), 32'b100);
         step();
         chk($sformatf("wr%0d_idle", t), 32'({busy, done}), 32'h0);
      end

      // ---- snapshot, out_ready high, cycle accurate ----
      data_mode = 1'b1; fixed_lat = 8'd0; out_ready = 1'b1;
      snap_req = 1'b1;
      step();
      for (int k = 1; k <= 2 * NR; k++) begin
         int i;
         i = (k - 1) / 2;
         if (k % 2 == 1) begin
            chk($sformatf("snap_rd%0d_bus", i), 32'({wb_cyc, wb_stb, wb_we, out_valid}), 32'b1100);
            chk($sformatf("snap_rd%0d_adr", i), wb_adr, 32'hf0030010 + 32'(4 * i));
         end else begin
            chk($sformatf("snap_w%0d_ctl", i), 32'({out_valid, wb_cyc, out_last}), {29'd0, 2'b10, (i == NR - 1)});
            chk($sformatf("snap_w%0d_data", i), out_data, 32'(32'h100 + i));
            chk($sformatf("snap_w%0d_index", i), 32'(out_index), 32'(i));
         end
         step();
      end
      chk("snap_finish", 32'({done, busy, out_valid, err}), 32'b1100);
      step();
      chk("snap_idle", 32'({done, busy}), 32'h0);

      // ---- backpressure on word 3 ----
      w0 = got_w.size();
      snap_req = 1'b1;
      step();
      wait_word(4'd3, 100);
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         chk($sformatf("bp_hold%0d", c), 32'({out_valid, wb_cyc, out_index}), 32'b1_0_0011);
         chk($sformatf("bp_data%0d", c), out_data, 32'h103);
      end
      out_ready = 1'b1;
      wait_idle(100);
      chk("bp_words", 32'(got_w.size() - w0), 32'(NR));
      for (int i = 0; i < NR && (w0 + i) < got_w.size(); i++)
         chk($sformatf("bp_word%0d", i), 32'({got_w[w0 + i].d[23:0], got_w[w0 + i].idx, 3'd0, got_w[w0 + i].last}),
             {24'(32'h100 + i), 4'(i), 3'd0, (i == NR - 1)});

      // ---- timeout on a snapshot ----
      fixed_lat = 8'd255; v0 = valid_cnt;
      snap_req = 1'b1;
      step();
      n = 0;
      while (wb_cyc && n < 200) begin n++; step(); end
      chk("to_cyc_cycles", 32'(n), 32'(TO));
      chk("to_done_err", 32'({done, err, out_valid, out_last}), 32'b1100);
      step();
      chk("to_err_held", 32'({err, busy}), 32'b10);
      chk("to_no_words", 32'(valid_cnt - v0), 32'h0);
      fixed_lat = 8'd0;
      wr_offset = 8'h00; wr_data = 32'h0; wr_req = 1'b1;
      step();
      chk("to_err_cleared", 32'(err), 32'h0);
      wait_idle(20);

      // ---- simultaneous requests and request while busy ----
      d0 = done_cnt; wr0 = got_wr.size(); r0 = rdcyc_cnt; w0 = got_w.size();
      wr_offset = 8'h08; wr_data = 32'ha5; wr_req = 1'b1; snap_req = 1'b1;
      step();
      chk("coll_write_taken", 32'({wb_cyc, wb_we}), 32'b11);
      wait_idle(20);
      fixed_lat = 8'd3;
      wr_offset = 8'h0c; wr_data = 32'h5a; wr_req = 1'b1;
      step();
      snap_req = 1'b1;
      step();
      wait_idle(20);
      repeat (10) step();
      chk("coll_done_count", 32'(done_cnt - d0), 32'd2);
      chk("coll_writes", 32'(got_wr.size() - wr0), 32'd2);
      chk("coll_no_reads", 32'(rdcyc_cnt - r0), 32'd0);
      chk("coll_no_words", 32'(got_w.size() - w0), 32'd0);
      if (got_wr.size() >= wr0 + 2) begin
         chk("coll_wr0_adr", got_wr[wr0].adr, 32'hf0030008);
         chk("coll_wr1_adr", got_wr[wr0 + 1].adr, 32'hf003000c);
      end

      // ---- reset during word 4 ----
      fixed_lat = 8'd0; out_ready = 1'b1;
      snap_req = 1'b1;
      step();
      wait_word(4'd4, 100);
      d0 = done_cnt;
      rst = 1'b1;
      step();
      chk("mrst_ctrl", 32'({busy, done, err, out_valid, out_last, wb_cyc, wb_stb, wb_we}), 32'h0);
      chk("mrst_regs", wb_adr | wb_dat_o | out_data | 32'(out_index), 32'h0);
      rst = 1'b0;
      step();
      chk("mrst_no_done", 32'({busy, done}), 32'h0);
      w0 = got_w.size();
      snap_req = 1'b1;
      step();
      chk("mrst_restart_adr", wb_adr, 32'hf0030010);
      chk("mrst_restart_idx", 32'({wb_cyc, out_index}), 32'b1_0000);
      wait_idle(100);
      chk("mrst_restart_words", 32'(got_w.size() - w0), 32'(NR));
      chk("mrst_done_count", 32'(done_cnt - d0), 32'd1);

      // ---- randomized run against transaction model ----
      data_mode = 1'b0; rand_lat = 1'b1; rand_rdy = 1'b1; noise = 1'b1;
      w0 = got_w.size(); wr0 = got_wr.size(); d0 = done_cnt;
      for (int t = 0; t < 40; t++) begin
         wait_idle(500);
         if ($urandom_range(0, 1) == 1) begin
            wr_offset = {6'($urandom_range(0, 63)), 2'b00};
            wr_data   = $urandom;
            exp_wr.push_back('{BASE + {24'd0, wr_offset}, wr_data});
            wr_req = 1'b1;
         end else begin
            for (int i = 0; i < NR; i++) exp_w.push_back('{exp_data(i), 4'(i), (i == NR - 1)});
            snap_req = 1'b1;
         end
         step();
      end
      wait_idle(500);
      noise = 1'b0; rand_rdy = 1'b0; out_ready = 1'b1;
      repeat (5) step();
      chk("rnd_done_count", 32'(done_cnt - d0), 32'd40);
      chk("rnd_write_count", 32'(got_wr.size() - wr0), 32'(exp_wr.size()));
      chk("rnd_word_count", 32'(got_w.size() - w0), 32'(exp_w.size()));
      for (int i = 0; i < exp_wr.size() && (wr0 + i) < got_wr.size(); i++) begin
         chk($sformatf("rnd_wr%0d_adr", i), got_wr[wr0 + i].adr, exp_wr[i].adr);
         chk($sformatf("rnd_wr%0d_dat", i), got_wr[wr0 + i].dat, exp_wr[i].dat);
      end
      for (int i = 0; i < exp_w.size() && (w0 + i) < got_w.size(); i++) begin
         chk($sformatf("rnd_w%0d_data", i), got_w[w0 + i].d, exp_w[i].d);
         chk($sformatf("rnd_w%0d_tag", i), 32'({got_w[w0 + i].idx, got_w[w0 + i].last}),
             32'({exp_w[i].idx, exp_w[i].last}));
      end

      chk("stream_hold_violations", 32'(hold_bad), 32'h0);
      chk("bus_active_in_push", 32'(push_bus_bad), 32'h0);
      chk("out_last_mismatches", 32'(last_bad), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
